// File: rtl/elevador_ctrl.sv
// ----------------------------------------------------------------------------
// elevador_ctrl
//
// Elevator car controller. It latches floor calls, moves the car using a
// collective (SCAN) policy, times floor transit and door dwell, and exports
// the floor index, a 2-bit direction code for the direction display, and the
// status bits for the panel LEDs.
//
// Parameters:
//   FLOORS       number of floors (2..16), numbered 0..FLOORS-1
//   MOVE_CYCLES  clock cycles to travel one floor (>=1)
//   DOOR_CYCLES  clock cycles the door stays open (>=1)
//   FW           floor index width, $clog2(FLOORS) (derived)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   call       in   [FLOORS] floor call requests, bit i = floor i
//   floor      out  [FW] current car floor
//   dir_code   out  [2] 00 stopped, 01 up, 10 down, 11 door open
//   door_open  out  door open
//   moving     out  car travelling between floors
//   pending    out  [FLOORS] latched, not-yet-served calls
//   door_hold  in   holds the door open (only with ELEV_DOOR_HOLD_EN)
//
// Build option:
//   ELEV_DOOR_HOLD_EN  adds door_hold; while in DOOR with door_hold=1 the
//                      door counter is held at 0.
// ----------------------------------------------------------------------------
module elevador_ctrl #(
    parameter int FLOORS      = 4,
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 8,
    localparam int FW         = $clog2(FLOORS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLOORS-1:0] call,
    output logic [FW-1:0]     floor,
    output logic [1:0]        dir_code,
    output logic              door_open,
    output logic              moving,
    output logic [FLOORS-1:0] pending
`ifdef ELEV_DOOR_HOLD_EN
    ,
    input  logic              door_hold
`endif
);

    localparam int MAXC = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    // State encoding equals the display code, so dir_code is the state itself.
    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_MOVE_UP   = 2'b01,
        S_MOVE_DOWN = 2'b10,
        S_DOOR      = 2'b11
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    state_e            state_q, state_d;
    dir_e              last_dir_q, last_dir_d;
    logic [FW-1:0]     floor_q, floor_d;
    logic [FLOORS-1:0] pending_q, pending_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              above, below;
    logic              door_entry;
    logic [FW-1:0]     serve_floor;
    logic [FW-1:0]     next_floor;
    logic              door_restart;

    // Any latched request strictly above / below the current floor.
    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (pending_q[i] && (i > int'(floor_q))) above = 1'b1;
            if (pending_q[i] && (i < int'(floor_q))) below = 1'b1;
        end
    end

    // A call for the current floor while the door is open restarts the dwell;
    // with the hold option, door_hold pins the counter at 0 the same way.
    always_comb begin
        door_restart = call[floor_q];
`ifdef ELEV_DOOR_HOLD_EN
        door_restart = door_restart | door_hold;
`endif
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        last_dir_d  = last_dir_q;
        floor_d     = floor_q;
        pending_d   = pending_q | call;
        cnt_d       = cnt_q + CW'(1);
        door_entry  = 1'b0;
        serve_floor = floor_q;
        next_floor  = floor_q;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (pending_q[floor_q]) begin
                    state_d    = S_DOOR;
                    door_entry = 1'b1;
                end else if (above) begin
                    state_d    = S_MOVE_UP;
                    last_dir_d = DIR_UP;
                end else if (below) begin
                    state_d    = S_MOVE_DOWN;
                    last_dir_d = DIR_DOWN;
                end
            end

            S_MOVE_UP, S_MOVE_DOWN: begin
                if (cnt_q == CW'(MOVE_CYCLES - 1)) begin
                    cnt_d      = '0;
                    next_floor = (state_q == S_MOVE_UP) ? floor_q + FW'(1)
                                                        : floor_q - FW'(1);
                    floor_d    = next_floor;
                    if (pending_q[next_floor]) begin
                        state_d     = S_DOOR;
                        door_entry  = 1'b1;
                        serve_floor = next_floor;
                    end
                end
            end

            S_DOOR: begin
                // The floor being served is never re-latched while open.
                pending_d[floor_q] = pending_q[floor_q];
                if (door_restart) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(DOOR_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (last_dir_q == DIR_UP && above) begin
                        state_d = S_MOVE_UP;
                    end else if (last_dir_q == DIR_DOWN && below) begin
                        state_d = S_MOVE_DOWN;
                    end else if (above) begin
                        state_d    = S_MOVE_UP;
                        last_dir_d = DIR_UP;
                    end else if (below) begin
                        state_d    = S_MOVE_DOWN;
                        last_dir_d = DIR_DOWN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Serving a floor clears its bit, overriding a same-edge call to it.
        if (door_entry) begin
            pending_d[serve_floor] = 1'b0;
            cnt_d                  = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            last_dir_q <= DIR_UP;
            floor_q    <= '0;
            pending_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            floor_q    <= floor_d;
            pending_q  <= pending_d;
            cnt_q      <= cnt_d;
        end
    end

    // Outputs decode registered state only; no input reaches them directly.
    always_comb begin
        floor     = floor_q;
        pending   = pending_q;
        dir_code  = state_q;
        door_open = (state_q == S_DOOR);
        moving    = (state_q == S_MOVE_UP) || (state_q == S_MOVE_DOWN);
    end

endmodule

// File: tb/tb_elevador_ctrl.sv
// ----------------------------------------------------------------------------
// tb_elevador_ctrl
//
// Directed bench for elevador_ctrl with FLOORS=4, MOVE_CYCLES=4,
// DOOR_CYCLES=8. Inputs change and outputs are sampled on the falling edge;
// "edge t" below is the rising edge that samples a stimulus.
// ----------------------------------------------------------------------------
module tb_elevador_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] call;
    logic [1:0] floor;
    logic [1:0] dir_code;
    logic       door_open;
    logic       moving;
    logic [3:0] pending;
`ifdef ELEV_DOOR_HOLD_EN
    logic       door_hold;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    elevador_ctrl #(
        .FLOORS      (4),
        .MOVE_CYCLES (4),
        .DOOR_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .call      (call),
        .floor     (floor),
        .dir_code  (dir_code),
        .door_open (door_open),
        .moving    (moving),
        .pending   (pending)
`ifdef ELEV_DOOR_HOLD_EN
        ,
        .door_hold (door_hold)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Full status snapshot: floor, dir_code, door_open, moving, pending.
    task automatic check_all(input string tag, input logic [1:0] f, input logic [1:0] d,
                             input logic dopen, input logic mv, input logic [3:0] p);
        check({tag, ".floor"},     32'(floor),     32'(f));
        check({tag, ".dir_code"},  32'(dir_code),  32'(d));
        check({tag, ".door_open"}, 32'(door_open), 32'(dopen));
        check({tag, ".moving"},    32'(moving),    32'(mv));
        check({tag, ".pending"},   32'(pending),   32'(p));
    endtask

    // Assert reset in the low clock phase, check outputs before any edge,
    // then release on a falling edge.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_all(tag, 2'd0, 2'b00, 1'b0, 1'b0, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
    endtask

    // One-cycle pulse sampled by the next rising edge (edge t).
    task automatic pulse(input logic [3:0] c);
        call = c;
        tick(1);
        call = 4'b0000;
    endtask

    initial begin
        rst_n = 1'b1;
        call  = 4'b0000;
`ifdef ELEV_DOOR_HOLD_EN
        door_hold = 1'b0;
`endif
        @(negedge clk);
        do_reset("rst_init");

        // ---- Same-floor call with dwell restart ----
        pulse(4'b0001);                               // edge t
        check_all("same_t", 2'd0, 2'b00, 1'b0, 1'b0, 4'b0001);
        tick(1);                                      // edge d = t+1
        check_all("same_d", 2'd0, 2'b11, 1'b1, 1'b0, 4'b0000);
        tick(4);                                      // after d+4
        pulse(4'b0001);                               // restart at edge d+5
        check_all("same_restart", 2'd0, 2'b11, 1'b1, 1'b0, 4'b0000);
        tick(7);                                      // after d+12
        check("same_open_d12", 32'(door_open), 32'd1);
        tick(1);                                      // after d+13
        check_all("same_close", 2'd0, 2'b00, 1'b0, 1'b0, 4'b0000);

        // ---- Call to floor 2 from floor 0 ----
        pulse(4'b0100);                               // edge t
        check_all("c2_t", 2'd0, 2'b00, 1'b0, 1'b0, 4'b0100);
        tick(1);
        check_all("c2_t1", 2'd0, 2'b01, 1'b0, 1'b1, 4'b0100);
        tick(3);
        check("c2_t4_floor", 32'(floor), 32'd0);
        tick(1);
        check_all("c2_t5", 2'd1, 2'b01, 1'b0, 1'b1, 4'b0100);
        tick(3);
        check("c2_t8_floor", 32'(floor), 32'd1);
        tick(1);
        check_all("c2_t9", 2'd2, 2'b11, 1'b1, 1'b0, 4'b0000);
        tick(7);
        check("c2_t16_dir", 32'(dir_code), 32'h3);
        tick(1);
        check_all("c2_t17", 2'd2, 2'b00, 1'b0, 1'b0, 4'b0000);

        // ---- SCAN ordering ----
        do_reset("rst_scan");
        pulse(4'b1000);                               // edge t
        tick(1);
        check("scan_t1_dir", 32'(dir_code), 32'h1);
        tick(4);
        check_all("scan_t5", 2'd1, 2'b01, 1'b0, 1'b1, 4'b1000);
        pulse(4'b0101);                               // edge t+6
        check("scan_t6_pending", 32'(pending), 32'hD);
        tick(3);
        check_all("scan_stop2", 2'd2, 2'b11, 1'b1, 1'b0, 4'b1001);
        tick(8);
        check_all("scan_up_again", 2'd2, 2'b01, 1'b0, 1'b1, 4'b1001);
        tick(4);
        check_all("scan_stop3", 2'd3, 2'b11, 1'b1, 1'b0, 4'b0001);
        tick(8);
        check_all("scan_reverse", 2'd3, 2'b10, 1'b0, 1'b1, 4'b0001);
        tick(12);
        check_all("scan_stop0", 2'd0, 2'b11, 1'b1, 1'b0, 4'b0000);
        tick(8);
        check_all("scan_idle", 2'd0, 2'b00, 1'b0, 1'b0, 4'b0000);

        // ---- Reset mid-transit ----
        do_reset("rst_pre_transit");
        pulse(4'b1100);
        tick(5);
        check_all("mid_before", 2'd1, 2'b01, 1'b0, 1'b1, 4'b1100);
        do_reset("mid_reset");
        tick(10);
        check_all("mid_after", 2'd0, 2'b00, 1'b0, 1'b0, 4'b0000);

`ifdef ELEV_DOOR_HOLD_EN
        // ---- Door hold ----
        pulse(4'b0001);
        tick(1);                                      // edge d
        check("hold_entry", 32'(door_open), 32'd1);
        door_hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("hold_open", 32'(door_open), 32'd1);
        end
        door_hold = 1'b0;
        tick(7);
        check("hold_release_7", 32'(door_open), 32'd1);
        tick(1);
        check("hold_release_8", 32'(door_open), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/elevador_ctrl.md
# elevador_ctrl

Elevator car controller for the PBL elevator design. It latches floor calls and sequences car movement with a collective (SCAN) policy. It times floor transit and door dwell, and drives the 2-bit direction code consumed by the direction 7-segment display decoder. It also exports the current floor and status for the floor display and the panel LEDs.

## Interface
Parameters:
- FLOORS, 4, number of floors (2..16); floors numbered 0..FLOORS-1
- MOVE_CYCLES, 4, clock cycles to travel one floor (>=1)
- DOOR_CYCLES, 8, clock cycles the door stays open (>=1)
- FW, derived, $clog2(FLOORS), floor index width

Ports:
- clk  in  1  system clock, rising edge; the only clock in the block
- rst_n  in  1  asynchronous, active-low reset
- call  in  FLOORS  floor call requests; bit i requests floor i; level or pulse, sampled each edge
- floor  out  FW  current car floor
- dir_code  out  2  display code: 00 stopped, 01 going up, 10 going down, 11 door open
- door_open  out  1  door open
- moving  out  1  car travelling between floors
- pending  out  FLOORS  latched, not-yet-served calls
- door_hold  in  1  present only with ELEV_DOOR_HOLD_EN; holds the door open

## Operation
- States:
  - IDLE: dir_code 00
  - MOVE_UP: dir_code 01, moving=1
  - MOVE_DOWN: dir_code 10, moving=1
  - DOOR: dir_code 11, door_open=1
- A last_dir flag (up/down) is kept for SCAN. It resets to up.
- Latching: every edge, pending <= pending | call. Exceptions:
  - a call for `floor` while in DOOR is not latched; it restarts the door timer instead.
  - the bit being served at DOOR entry is cleared, and clearing wins over a simultaneous call to the same floor.
- "above" = any pending bit > floor; "below" = any pending bit < floor.
- IDLE decision priority:
  1. pending[floor] -> DOOR
  2. above -> MOVE_UP
  3. below -> MOVE_DOWN
  4. otherwise stay in IDLE
- MOVE_x:
  - the transit counter counts MOVE_CYCLES.
  - on expiry, floor is stepped by ±1.
  - if pending[new floor] is set, go to DOOR; otherwise stay in MOVE_x and restart the counter.
  - last_dir is updated on every entry to MOVE_x.
- DOOR: the door counter counts DOOR_CYCLES. On expiry:
  1. a request in last_dir's direction -> continue that way
  2. else a request in the opposite direction -> reverse
  3. else IDLE
- Floor bounds: floor never leaves 0..FLOORS-1. A car moving toward an end always has a pending target at or before that end, so no wrap-around occurs.
- Arithmetic: counters are $clog2(max(MOVE_CYCLES, DOOR_CYCLES)+1) bits wide and reload to 0 on every state entry.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - floor=0, dir_code=00, door_open=0, moving=0, pending=0
  - state IDLE, last_dir up, counters 0
- Reset mid-move or mid-door aborts the operation and loses all calls.
- A call sampled at edge t shows in pending after t. IDLE acts on it at edge t+1, so dir_code changes at t+1.
- Transit: MOVE entered at edge e -> floor changes at edge e+MOVE_CYCLES. When that arrival opens the door, state goes to DOOR on the same edge.
- Door: DOOR entered at edge d -> door_open stays 1 for exactly DOOR_CYCLES cycles and the exit decision happens at edge d+DOOR_CYCLES. A restart pushes the exit out to DOOR_CYCLES edges after the restarting edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- ELEV_DOOR_HOLD_EN defined:
  - the door_hold port exists.
  - while in DOOR with door_hold=1, the door counter is held at 0, so the door stays open indefinitely.
  - release gives a full DOOR_CYCLES dwell.
  - door_hold has no effect outside DOOR.
- Undefined: no door_hold port, and the door dwell is always DOOR_CYCLES cycles plus any call restarts.

## Test plan
All scenarios use FLOORS=4, MOVE_CYCLES=4, DOOR_CYCLES=8.
- Reset: drive rst_n low mid-operation -> floor=0, dir_code=00, door_open=0, moving=0 and pending=0 immediately, without waiting for a clock edge.
- Call to floor 2 from idle at floor 0, one-cycle pulse on call[2] at edge t:
  - dir_code=01 from t+1
  - floor=1 at t+5, floor=2 at t+9
  - door_open=1 and dir_code=11 from t+9 for 8 cycles, pending[2] cleared at t+9
  - then dir_code=00
- Same-floor call: call[0] while idle at floor 0 -> DOOR next edge, dir_code=11.
  - a call[0] pulse at door cycle 5 restarts dwell: door_open lasts 5+8 cycles total, and pending[0] stays 0.
- SCAN order: car moving up from floor 0 toward 3; at floor 1, pulse call[0] and call[2] together:
  - stops in order 2, then 3, then 0
  - dir_code sequence 01, 11, 01, 11, 10, 11, 00
- Reset mid-transit: rst_n low while floor=1 moving up with pending=1100 -> immediate floor=0, pending=0. After release, the block stays IDLE with no call.
- With ELEV_DOOR_HOLD_EN: door_hold=1 for 20 cycles during DOOR -> door_open stays 1 throughout, then exactly 8 more cycles after release.
